// File: rtl/axi_addr_xbar.sv
// rtl/axi_addr_xbar.sv - AXI address-channel crossbar with round-robin arbitration and outstanding limiting
module axi_addr_xbar #(
  parameter int NM      = 3,
  parameter int NS      = 6,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 1,
  parameter logic [NS*ADDR_W-1:0] SLV_BASE = {32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
                                              32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NS*ADDR_W-1:0] SLV_MASK = {NS{32'hFFFF_0000}}
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NM*ID_W-1:0]                              m_id,
  input  logic [NM*ADDR_W-1:0]                            m_addr,
  input  logic [NM*8-1:0]                                 m_len,
  input  logic [NM*3-1:0]                                 m_size,
  input  logic [NM*2-1:0]                                 m_burst,
  input  logic [NM-1:0]                                   m_valid,
  output logic [NM-1:0]                                   m_ready,
  output logic [NS*(ID_W+((NM > 1) ? $clog2(NM) : 1))-1:0] s_id,
  output logic [NS*ADDR_W-1:0]                            s_addr,
  output logic [NS*8-1:0]                                 s_len,
  output logic [NS*3-1:0]                                 s_size,
  output logic [NS*2-1:0]                                 s_burst,
  output logic [NS-1:0]                                   s_valid,
  input  logic [NS-1:0]                                   s_ready,
  input  logic [NS-1:0]                                   s_done,
  output logic                                            decerr_valid,
  output logic [ID_W+((NM > 1) ? $clog2(NM) : 1)-1:0]     decerr_id,
  output logic [7:0]                                      decerr_len,
  input  logic                                            decerr_ready
);

  localparam int MW    = (NM > 1) ? $clog2(NM) : 1;
  localparam int IDS_W = ID_W + MW;
  // Target code NS is the internal decode-error slave.
  localparam int TW    = $clog2(NS + 1);

  logic              hold_valid;
  logic [TW-1:0]     hold_tgt;
  logic [IDS_W-1:0]  hold_id;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0]        hold_len;
  logic [2:0]        hold_size;
  logic [1:0]        hold_burst;
  logic [3:0]        cnt [NS];
  logic [MW-1:0]     ptr;

  logic [TW-1:0]     tgt [NM];
  logic [NS:0]       can_acc;
  logic [NS:0]       ready_ext;
  logic [NM-1:0]     elig;
  logic              drain;
  logic              found;
  logic [MW-1:0]     gnt;
  logic              capture;

  // Lowest matching slave wins; no match falls through to the default slave.
  function automatic logic [TW-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [TW-1:0] t;
    t = TW'(NS);
    for (int i = NS - 1; i >= 0; i--) begin
      if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) t = TW'(i);
    end
    return t;
  endfunction

  // Decode every master's target and work out which targets have room.
  always_comb begin
    for (int j = 0; j < NM; j++) tgt[j] = decode(m_addr[j*ADDR_W +: ADDR_W]);
    can_acc = '0;
    for (int t = 0; t < NS; t++) begin
      can_acc[t] = ({1'b0, cnt[t]} + 5'(hold_valid && (hold_tgt == TW'(t)))) < 5'(MAX_OUT);
    end
    can_acc[NS] = 1'b1;
    for (int j = 0; j < NM; j++) elig[j] = m_valid[j] && can_acc[tgt[j]];
  end

  // The holding entry leaves when its target (mapped or default) accepts it.
  always_comb begin
    ready_ext = {decerr_ready, s_ready};
    drain     = hold_valid && ready_ext[hold_tgt];
  end

  // Round-robin: first eligible master at or after the pointer.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NM; k++) begin
      if (!found && elig[(int'(ptr) + k) % NM]) begin
        found = 1'b1;
        gnt   = MW'((int'(ptr) + k) % NM);
      end
    end
    capture = rst && found && (!hold_valid || drain);
    m_ready = capture ? (NM'(1) << gnt) : '0;
  end

  // Holding register: load on capture, empty when drained without refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_tgt   <= '0;
      hold_id    <= '0;
      hold_addr  <= '0;
      hold_len   <= '0;
      hold_size  <= '0;
      hold_burst <= '0;
      ptr        <= '0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_tgt   <= tgt[gnt];
      hold_id    <= {gnt, m_id[gnt*ID_W +: ID_W]};
      hold_addr  <= m_addr[gnt*ADDR_W +: ADDR_W];
      hold_len   <= m_len[gnt*8 +: 8];
      hold_size  <= m_size[gnt*3 +: 3];
      hold_burst <= m_burst[gnt*2 +: 2];
      ptr        <= (int'(gnt) == NM - 1) ? '0 : gnt + MW'(1);
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

  // Outstanding counters: up on slave handshake, down on completion, floor at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NS; t++) cnt[t] <= '0;
    end else begin
      for (int t = 0; t < NS; t++) begin
        if ((s_valid[t] && s_ready[t]) && !(s_done[t] && cnt[t] != '0)) begin
          cnt[t] <= cnt[t] + 4'd1;
        end else if (!(s_valid[t] && s_ready[t]) && s_done[t] && cnt[t] != '0) begin
          cnt[t] <= cnt[t] - 4'd1;
        end
      end
    end
  end

  // Payload is broadcast; only the valids select a destination.
  always_comb begin
    for (int t = 0; t < NS; t++) s_valid[t] = hold_valid && (hold_tgt == TW'(t));
    decerr_valid = hold_valid && (hold_tgt == TW'(NS));
    s_id         = {NS{hold_id}};
    s_addr       = {NS{hold_addr}};
    s_len        = {NS{hold_len}};
    s_size       = {NS{hold_size}};
    s_burst      = {NS{hold_burst}};
    decerr_id    = hold_id;
    decerr_len   = hold_len;
  end

endmodule
